// File: rtl/rsa_ctrl.sv
// rtl/rsa_ctrl.sv - RSA sequencer: keygen control, key latch, round-robin modexp sharing
module rsa_ctrl #(
  parameter int PW      = 8,
  parameter int W       = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [PW-1:0]  cfg_p,
  input  logic [PW-1:0]  cfg_q,
  output logic           key_valid,
  output logic [PW-1:0]  pub_e,
  output logic [W-1:0]   pub_n,
  output logic           kg_start,
  output logic [PW-1:0]  kg_p,
  output logic [PW-1:0]  kg_q,
  input  logic [PW-1:0]  kg_e,
  input  logic [W-1:0]   kg_d,
  input  logic [W-1:0]   kg_n,
  input  logic           kg_finish,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [1:0]     req_op,
  input  logic [2*W-1:0] req_msg,
  output logic [1:0]     rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           me_start,
  output logic [W-1:0]   me_base,
  output logic [W-1:0]   me_exp,
  output logic [W-1:0]   me_mod,
  input  logic [W-1:0]   me_result,
  input  logic           me_done,
  output logic           busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {NOKEY, KEYGEN, READY, GRANT, EXEC, RESP} state_t;

  state_t         state;
  logic [W-1:0]   key_d;
  logic [CW-1:0]  tmr;
  logic           me_pend;   // operands loaded, me_start still to be issued
  logic           gsel;      // requester owning the operation in flight
  logic           last_g;    // last granted requester; reset to 1 so requester 0 wins first
  logic           pick;
  logic           pick_op;
  logic [W-1:0]   pick_msg;
  logic [1:0]     pick_vec;
  logic           tmr_expired;

  assign cfg_ready   = (state == NOKEY) || (state == READY);
  assign busy        = (state == KEYGEN) || (state == GRANT) || (state == EXEC) || (state == RESP);
  assign tmr_expired = (tmr == CW'(TIMEOUT - 1));

  // Round-robin choice: on contention take the requester not granted last
  always_comb begin
    pick     = (req_valid == 2'b11) ? ~last_g : req_valid[1];
    pick_op  = pick ? req_op[1] : req_op[0];
    pick_msg = pick ? req_msg[2*W-1:W] : req_msg[W-1:0];
    pick_vec = pick ? 2'b10 : 2'b01;
  end

  // Main sequencer; kg_finish/me_done are ignored in the start cycle so stale levels never complete a new run
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NOKEY;
      key_valid <= 1'b0;
      pub_e     <= '0;
      pub_n     <= '0;
      key_d     <= '0;
      kg_start  <= 1'b0;
      kg_p      <= '0;
      kg_q      <= '0;
      req_ready <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      me_start  <= 1'b0;
      me_base   <= '0;
      me_exp    <= '0;
      me_mod    <= '0;
      me_pend   <= 1'b0;
      tmr       <= '0;
      gsel      <= 1'b0;
      last_g    <= 1'b1;
    end else begin
      kg_start  <= 1'b0;
      me_start  <= 1'b0;
      req_ready <= 2'b00;
      rsp_valid <= 2'b00;
      case (state)
        NOKEY: begin
          if (cfg_valid) begin
            kg_p     <= cfg_p;
            kg_q     <= cfg_q;
            kg_start <= 1'b1;
            tmr      <= '0;
            state    <= KEYGEN;
          end else if (|req_valid) begin
            req_ready <= pick_vec;
            gsel      <= pick;
            last_g    <= pick;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end
        end
        KEYGEN: begin
          if (kg_finish && !kg_start) begin
            pub_e     <= kg_e;
            key_d     <= kg_d;
            pub_n     <= kg_n;
            key_valid <= 1'b1;
            state     <= READY;
          end else if (tmr_expired) begin
            state <= NOKEY;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        READY: begin
          if (cfg_valid) begin
            key_valid <= 1'b0;
            kg_p      <= cfg_p;
            kg_q      <= cfg_q;
            kg_start  <= 1'b1;
            tmr       <= '0;
            state     <= KEYGEN;
          end else if (|req_valid) begin
            state <= GRANT;
          end
        end
        GRANT: begin
          if (|req_valid) begin
            req_ready <= pick_vec;
            gsel      <= pick;
            last_g    <= pick;
            me_base   <= pick_msg;
            me_exp    <= pick_op ? key_d : W'(pub_e);
            me_mod    <= pub_n;
            if (pick_msg >= pub_n) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
              state    <= RESP;
            end else begin
              me_pend <= 1'b1;
              state   <= EXEC;
            end
          end else begin
            state <= READY;
          end
        end
        EXEC: begin
          if (me_pend) begin
            me_start <= 1'b1;
            me_pend  <= 1'b0;
            tmr      <= '0;
          end else if (me_done && !me_start) begin
            rsp_data <= me_result;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (tmr_expired) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= gsel ? 2'b10 : 2'b01;
          state     <= key_valid ? READY : NOKEY;
        end
        default: state <= NOKEY;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_ctrl.sv
// tb/tb_rsa_ctrl.sv - directed self-checking bench for rsa_ctrl
module tb_rsa_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_p, cfg_q;
  logic        key_valid;
  logic [7:0]  pub_e;
  logic [15:0] pub_n;
  logic        kg_start;
  logic [7:0]  kg_p, kg_q;
  logic [7:0]  kg_e = '0;
  logic [15:0] kg_d = '0;
  logic [15:0] kg_n = '0;
  logic        kg_finish = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_msg;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        me_start;
  logic [15:0] me_base, me_exp, me_mod;
  logic [15:0] me_result = '0;
  logic        me_done = 1'b0;
  logic        busy;

  rsa_ctrl #(.PW(8), .W(16), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_p(cfg_p), .cfg_q(cfg_q),
    .key_valid(key_valid), .pub_e(pub_e), .pub_n(pub_n),
    .kg_start(kg_start), .kg_p(kg_p), .kg_q(kg_q),
    .kg_e(kg_e), .kg_d(kg_d), .kg_n(kg_n), .kg_finish(kg_finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_msg(req_msg),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .me_start(me_start), .me_base(me_base), .me_exp(me_exp), .me_mod(me_mod),
    .me_result(me_result), .me_done(me_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;
  logic [15:0] last_exp = '0;
  logic me_hang = 1'b0;
  logic inject = 1'b0;
  int kg_cnt = 0;

  typedef struct {
    int          idx;
    logic        op;
    logic [15:0] msg;
    logic [15:0] data;
    logic        err;
    int          lat;
    logic [15:0] exp_e;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    logic [31:0] r, x;
    if (m == 0) return 16'd0;
    r = 1;
    x = {16'd0, b} % {16'd0, m};
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % {16'd0, m};
      x = (x * x) % {16'd0, m};
    end
    return r[15:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // KeyGen model: finishes 3 cycles after start with the textbook key for p, q
  always @(posedge clk) begin
    kg_finish <= 1'b0;
    if (kg_start) kg_cnt <= 3;
    else if (kg_cnt != 0) begin
      kg_cnt <= kg_cnt - 1;
      if (kg_cnt == 1) begin
        kg_finish <= 1'b1;
        kg_e <= 8'd3;
        kg_d <= 16'd2011;
        kg_n <= kg_p * kg_q;
      end
    end
  end

  // Modexp model: done one cycle after start unless hung; inject forces a stray done
  always @(posedge clk) begin
    me_done <= (me_start && !me_hang) || inject;
    if (me_start) me_result <= modexp(me_base, me_exp, me_mod);
  end

  always @(negedge clk) begin
    if (me_start) begin
      last_exp = me_exp;
      n_start  = n_start + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input string tag);
    int lat;
    int starts0;
    bit got;
    @(negedge clk);
    starts0 = n_start;
    req_valid[v.idx] = 1'b1;
    req_op[v.idx] = v.op;
    req_msg[v.idx*16 +: 16] = v.msg;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got = 1;
    end
    chk({tag, "_grant"}, {30'd0, req_ready}, 32'd1 << v.idx);
    req_valid = 2'b00;
    got = 0;
    lat = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != 2'b00) got = 1;
    end
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd1 << v.idx);
    chk({tag, "_rsp_data"}, {16'd0, rsp_data}, {16'd0, v.data});
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, v.err});
    chk({tag, "_latency"}, lat, v.lat);
    if (v.err) chk({tag, "_no_me_start"}, n_start - starts0, 0);
    else chk({tag, "_me_exp"}, {16'd0, last_exp}, {16'd0, v.exp_e});
  endtask

  task automatic do_keygen(input string tag);
    bit got;
    @(negedge clk);
    cfg_p = 8'd53;
    cfg_q = 8'd59;
    cfg_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_kg_start"}, {31'd0, kg_start}, 1);
    chk({tag, "_kg_pq"}, {16'd0, kg_p, kg_q}, {16'd0, 8'd53, 8'd59});
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_kg_start_pulse"}, {31'd0, kg_start}, 0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (key_valid) got = 1;
    end
    chk({tag, "_key_valid"}, {31'd0, key_valid}, 1);
    chk({tag, "_pub_e"}, {24'd0, pub_e}, 3);
    chk({tag, "_pub_n"}, {16'd0, pub_n}, 3127);
  endtask

  initial begin
    vec_t v;
    bit got;
    int t0, t1, extra, rsp_seen;
    logic [1:0] g_exp[3];
    logic [15:0] d_exp[3];

    vecs[0] = '{0, 1'b0, 16'd65,   16'd2576, 1'b0, 4, 16'd3};
    vecs[1] = '{1, 1'b1, 16'd2576, 16'd65,   1'b0, 4, 16'd2011};
    vecs[2] = '{0, 1'b0, 16'd3127, 16'd0,    1'b1, 1, 16'd0};
    vecs[3] = '{1, 1'b0, 16'd3126, 16'd3126, 1'b0, 4, 16'd3};
    vecs[4] = '{0, 1'b1, 16'd0,    16'd0,    1'b0, 4, 16'd2011};
    vecs[5] = '{1, 1'b0, 16'd2,    16'd8,    1'b0, 4, 16'd3};

    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_p = '0;
    cfg_q = '0;
    req_valid = '0;
    req_op = '0;
    req_msg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("rst_key_valid", {31'd0, key_valid}, 0);
    chk("rst_pub", {8'd0, pub_e, pub_n}, 0);
    chk("rst_rsp", {13'd0, rsp_valid, rsp_err, rsp_data}, 0);
    chk("rst_pulses", {28'd0, kg_start, me_start, req_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    v = '{0, 1'b0, 16'd5, 16'd0, 1'b1, 1, 16'd0};
    do_req(v, "nokey");

    do_keygen("kg1");

    for (int i = 0; i < 6; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Contention: both held valid, grants must alternate and never overlap an operation
    g_exp[0] = 2'b01; g_exp[1] = 2'b10; g_exp[2] = 2'b01;
    d_exp[0] = 16'd8; d_exp[1] = 16'd27; d_exp[2] = 16'd8;
    @(negedge clk);
    req_op = 2'b00;
    req_msg = {16'd3, 16'd2};
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) got = 1;
      end
      chk($sformatf("rr_grant%0d", k), {30'd0, req_ready}, {30'd0, g_exp[k]});
      extra = 0;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) extra++;
        if (rsp_valid != 2'b00) got = 1;
      end
      chk($sformatf("rr_rsp%0d", k), {30'd0, rsp_valid}, {30'd0, g_exp[k]});
      chk($sformatf("rr_data%0d", k), {16'd0, rsp_data}, {16'd0, d_exp[k]});
      chk($sformatf("rr_no_grant_busy%0d", k), extra, 0);
    end
    req_valid = 2'b00;

    // Timeout: hung modexp, rsp_err must rise exactly TIMEOUT cycles after me_start
    me_hang = 1'b1;
    @(negedge clk);
    req_op[0] = 1'b0;
    req_msg[15:0] = 16'd7;
    req_valid = 2'b01;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got = 1;
    end
    req_valid = 2'b00;
    got = 0;
    t0 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (me_start) begin got = 1; t0 = cyc; end
    end
    chk("to_me_start", {31'd0, got}, 1);
    got = 0;
    t1 = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_err) begin got = 1; t1 = cyc; end
    end
    chk("to_cycles", t1 - t0, 100);
    @(negedge clk);
    chk("to_rsp_valid", {30'd0, rsp_valid}, 1);
    chk("to_rsp", {15'd0, rsp_err, rsp_data}, {15'd0, 1'b1, 16'd0});
    chk("to_ready", {30'd0, busy, cfg_ready}, 1);
    me_hang = 1'b0;
    v = '{1, 1'b0, 16'd2, 16'd8, 1'b0, 4, 16'd3};
    do_req(v, "after_to");

    // Reset during EXEC, then a stale me_done that must be ignored
    me_hang = 1'b1;
    @(negedge clk);
    req_op[0] = 1'b0;
    req_msg[15:0] = 16'd10;
    req_valid = 2'b01;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) req_valid = 2'b00;
      if (me_start) got = 1;
    end
    req_valid = 2'b00;
    chk("mr_me_start", {31'd0, got}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) rsp_seen++;
    end
    chk("mr_no_rsp", rsp_seen, 0);
    chk("mr_key_valid", {31'd0, key_valid}, 0);
    chk("mr_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("mr_busy", {31'd0, busy}, 0);
    me_hang = 1'b0;
    do_keygen("kg2");
    v = '{0, 1'b0, 16'd65, 16'd2576, 1'b0, 4, 16'd3};
    do_req(v, "after_rekey");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
